// File: rtl/mem_pkg.sv
// Shared constants for the data-memory copy master: FSM encoding, write-enable levels, default widths.
package mem_pkg;

  localparam int DEF_ASIZE = 16;
  localparam int DEF_DSIZE = 16;

  localparam logic MEM_WEN_ACTIVE = 1'b0;
  localparam logic MEM_WEN_IDLE   = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WRITE   = 3'd3,
    FIN     = 3'd4
  } state_e;

endpackage

// File: rtl/mem_copy_master.sv
// Copies a fixed-length or zero-terminated block of words through the single-port data memory,
// one word every 3 cycles (read address, read data, write); all outputs registered.
module mem_copy_master
  import mem_pkg::*;
#(
  parameter int ASIZE = DEF_ASIZE,
  parameter int DSIZE = DEF_DSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ASIZE-1:0] src_addr,
  input  logic [ASIZE-1:0] dst_addr,
  input  logic [ASIZE-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ASIZE-1:0] words_done,
  output logic             mem_wen,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata
);

  localparam logic [ASIZE-1:0] ONE          = {{(ASIZE-1){1'b0}}, 1'b1};
  localparam logic [ASIZE-1:0] WD_PRE_LIMIT = {{(ASIZE-1){1'b1}}, 1'b0};

  state_e           state_q;
  logic [ASIZE-1:0] src_q;
  logic [ASIZE-1:0] dst_q;
  logic [ASIZE-1:0] rem_q;
  logic [ASIZE-1:0] words_done_q;
  logic [ASIZE-1:0] mem_addr_q;
  logic [DSIZE-1:0] mem_wdata_q;
  logic             term_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic             mem_wen_q;

  logic             limit_hit;
  logic             last_word;

  // mem_wdata_q doubles as the captured read word, so the write stage needs no extra register.
  always_comb begin
    limit_hit = term_q && (mem_wdata_q != '0) && (words_done_q == WD_PRE_LIMIT);
    last_word = term_q ? ((mem_wdata_q == '0) || limit_hit) : (rem_q == ONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      rem_q        <= '0;
      words_done_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      term_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      mem_wen_q    <= MEM_WEN_IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          mem_wen_q <= MEM_WEN_IDLE;
          if (start) begin
            src_q        <= src_addr;
            dst_q        <= dst_addr;
            rem_q        <= len;
            term_q       <= (len == '0);
            words_done_q <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            mem_addr_q   <= src_addr;
            state_q      <= RD_ADDR;
          end
        end
        RD_ADDR: begin
          // Address was presented on entry, so the memory returns the word during RD_DATA.
          mem_wen_q <= MEM_WEN_IDLE;
          state_q   <= RD_DATA;
        end
        RD_DATA: begin
          mem_wdata_q <= mem_rdata;
          mem_addr_q  <= dst_q;
          mem_wen_q   <= MEM_WEN_ACTIVE;
          state_q     <= WRITE;
        end
        WRITE: begin
          mem_wen_q    <= MEM_WEN_IDLE;
          src_q        <= src_q + ONE;
          dst_q        <= dst_q + ONE;
          words_done_q <= words_done_q + ONE;
          if (last_word) begin
            done_q  <= 1'b1;
            err_q   <= limit_hit;
            state_q <= FIN;
          end else begin
            rem_q      <= rem_q - ONE;
            mem_addr_q <= src_q + ONE;
            state_q    <= RD_ADDR;
          end
        end
        FIN: begin
          mem_wen_q <= MEM_WEN_IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          mem_wen_q <= MEM_WEN_IDLE;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_done_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench: two copy masters (16-bit and 8-bit address) on bench memories, checked against a word-by-word reference copy.
module tb_mem_copy_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start;
  logic [15:0] src_addr, dst_addr, len;
  logic        busy, done, err;
  logic [15:0] words_done, mem_addr, mem_wdata;
  logic        mem_wen;
  logic [15:0] mem_rdata;

  logic        s8_start;
  logic [7:0]  s8_src, s8_dst, s8_len;
  logic        s8_busy, s8_done, s8_err;
  logic [7:0]  s8_words_done, s8_mem_addr;
  logic [15:0] s8_mem_wdata;
  logic        s8_mem_wen;
  logic [15:0] s8_mem_rdata;

  mem_copy_master #(.ASIZE(16), .DSIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err), .words_done(words_done), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_copy_master #(.ASIZE(8), .DSIZE(16)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .src_addr(s8_src), .dst_addr(s8_dst), .len(s8_len),
    .busy(s8_busy), .done(s8_done), .err(s8_err), .words_done(s8_words_done), .mem_wen(s8_mem_wen),
    .mem_addr(s8_mem_addr), .mem_wdata(s8_mem_wdata), .mem_rdata(s8_mem_rdata)
  );

  // Bench memories with a backdoor write port used only while the masters are idle.
  logic [15:0] mem  [0:65535];
  logic [15:0] mem8 [0:255];
  logic [15:0] ref_mem [0:65535];
  logic        bd_we, bd8_we;
  logic [15:0] bd_addr, bd_data, bd8_data;
  logic [7:0]  bd8_addr;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_wen == 1'b0) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (bd8_we) mem8[bd8_addr] <= bd8_data;
    else if (s8_mem_wen == 1'b0) mem8[s8_mem_addr] <= s8_mem_wdata;
    s8_mem_rdata <= mem8[s8_mem_addr];
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference: ascending word-by-word copy with 16-bit wrapping pointers.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            output int n, output bit e);
    logic [15:0] sp, dp, w;
    sp = s; dp = d; n = 0; e = 1'b0;
    forever begin
      w = ref_mem[sp];
      ref_mem[dp] = w;
      n++; sp++; dp++;
      if (l != 16'h0) begin
        if (n == int'(l)) break;
      end else if (w == 16'h0) begin
        break;
      end else if (n == 65535) begin
        e = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_region(input string tag, input logic [15:0] d, input int cnt);
    logic [15:0] a;
    a = d;
    for (int i = 0; i < cnt; i++) begin
      check($sformatf("%s mem[%0h]", tag, a), 32'(mem[a]), 32'(ref_mem[a]));
      a++;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    int n, cyc;
    bit e, seen;
    model_copy(s, d, l, n, e);
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3 * n + 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    check({tag, " done"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(3 * n + 1));
    check({tag, " words_done"}, 32'(words_done), 32'(n));
    check({tag, " err"}, 32'(err), 32'(e));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check({tag, " busy clr"}, 32'(busy), 32'd0);
    check_region(tag, d, n + 1);
  endtask

  initial begin
    int k, cyc, wr_cnt, done_cnt;
    logic [15:0] s, d, l;
    bit fixed, seen;

    start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    s8_start = 1'b0; s8_src = '0; s8_dst = '0; s8_len = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    bd8_we = 1'b0; bd8_addr = '0; bd8_data = '0;

    #12;
    check("rst mem_wen", 32'(mem_wen), 32'd1);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst words_done", 32'(words_done), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Fixed length
    bd_write(16'h0010, 16'h00A1); bd_write(16'h0011, 16'h00B2);
    bd_write(16'h0012, 16'h00C3); bd_write(16'h0013, 16'h00D4);
    for (int i = 0; i < 5; i++) bd_write(16'(16'h0100 + i), 16'hDEAD);
    run_cmd("fixed", 16'h0010, 16'h0100, 16'd4);

    // Zero-terminated, mem[0x83] must remain untouched
    bd_write(16'h0020, 16'h1111); bd_write(16'h0021, 16'h2222); bd_write(16'h0022, 16'h0000);
    for (int i = 0; i < 4; i++) bd_write(16'(16'h0080 + i), 16'hBEEF);
    run_cmd("term", 16'h0020, 16'h0080, 16'd0);
    check("term guard", 32'(mem[16'h0083]), 32'h0000BEEF);

    // Source address wrap
    bd_write(16'hFFFE, 16'h5A5A); bd_write(16'hFFFF, 16'h6B6B); bd_write(16'h0000, 16'h7C7C);
    for (int i = 0; i < 4; i++) bd_write(16'(16'h0200 + i), 16'h1234);
    run_cmd("wrap", 16'hFFFE, 16'h0200, 16'd3);
    check("wrap last", 32'(mem[16'h0202]), 32'h00007C7C);

    // Start while busy is ignored
    bd_write(16'h0300, 16'h3030); bd_write(16'h0301, 16'h3131);
    for (int i = 0; i < 3; i++) bd_write(16'(16'h0400 + i), 16'h4444);
    bd_write(16'h0500, 16'h5555); bd_write(16'h0501, 16'h5555);
    bd_write(16'h0600, 16'h6666); bd_write(16'h0601, 16'h6767);
    model_copy(16'h0300, 16'h0400, 16'd2, k, seen);
    start = 1'b1; src_addr = 16'h0300; dst_addr = 16'h0400; len = 16'd2;
    done_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 2) begin
        check("busy at +2", 32'(busy), 32'd1);
        start = 1'b1; src_addr = 16'h0600; dst_addr = 16'h0500; len = 16'd2;
      end
      if (done) done_cnt++;
    end
    check("busy done count", 32'(done_cnt), 32'd1);
    check("busy words_done", 32'(words_done), 32'd2);
    check_region("busy", 16'h0400, 3);
    check_region("busy ignored", 16'h0500, 2);

    // Reset during the 4th write
    for (int i = 0; i < 8; i++) bd_write(16'(16'h0700 + i), 16'(16'h7000 + i + 1));
    for (int i = 0; i < 8; i++) bd_write(16'(16'h0800 + i), 16'hA5A5);
    start = 1'b1; src_addr = 16'h0700; dst_addr = 16'h0800; len = 16'd8;
    wr_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mem_wen == 1'b0) wr_cnt++;
      if (wr_cnt == 4) seen = 1'b1;
    end
    check("rstmid 4th write seen", 32'(seen), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid mem_wen", 32'(mem_wen), 32'd1);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid words_done", 32'(words_done), 32'd0);
    for (int i = 0; i < 3; i++) ref_mem[16'(16'h0800 + i)] = ref_mem[16'(16'h0700 + i)];
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_region("rstmid", 16'h0800, 8);
    bd_write(16'h0900, 16'h0000);
    run_cmd("after rst", 16'h0707, 16'h0900, 16'd1);

    // Randomized commands, including forward-overlapping fixed copies
    for (int it = 0; it < 10; it++) begin
      fixed = ($urandom_range(0, 1) == 1);
      s = 16'($urandom);
      k = int'($urandom_range(1, 6));
      if (fixed) begin
        d = ($urandom_range(0, 1) == 1) ? 16'(s + 16'($urandom_range(1, 4))) : 16'($urandom);
        l = 16'(k);
        for (int i = 0; i < k; i++) bd_write(16'(s + i), 16'($urandom));
      end else begin
        d = 16'(s + 16'h1000 + 16'($urandom_range(0, 255)));
        l = 16'h0;
        for (int i = 0; i < k - 1; i++) bd_write(16'(s + i), 16'($urandom_range(1, 65535)));
        bd_write(16'(s + k - 1), 16'h0000);
      end
      for (int i = 0; i <= k; i++) bd_write(16'(d + i), 16'($urandom));
      run_cmd($sformatf("rand%0d", it), s, d, l);
    end

    // Terminated-mode word limit on the 8-bit address instance
    for (int i = 0; i < 256; i++) begin
      bd8_we = 1'b1; bd8_addr = 8'(i); bd8_data = 16'hFFFF;
      @(posedge clk); #1;
    end
    bd8_we = 1'b0;
    s8_start = 1'b1; s8_src = 8'h00; s8_dst = 8'h80; s8_len = 8'h00;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 3 * 255 + 50) begin
      @(posedge clk); #1;
      s8_start = 1'b0;
      cyc++;
      if (s8_done) seen = 1'b1;
    end
    check("limit done", 32'(seen), 32'd1);
    check("limit latency", 32'(cyc), 32'(3 * 255 + 1));
    check("limit err", 32'(s8_err), 32'd1);
    check("limit words_done", 32'(s8_words_done), 32'h000000FF);
    check("limit mem8", 32'(mem8[8'h7E]), 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    check("limit err held", 32'(s8_err), 32'd1);
    check("limit busy", 32'(s8_busy), 32'd0);
    s8_start = 1'b1; s8_src = 8'h10; s8_dst = 8'h20; s8_len = 8'h01;
    @(posedge clk); #1;
    s8_start = 1'b0;
    check("limit err cleared", 32'(s8_err), 32'd0);
    check("limit busy set", 32'(s8_busy), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("limit next words_done", 32'(s8_words_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Initiator that drives the single-port data memory bus (clk, wen active-low, addr, data_in, data_out).
- Copies a block of words from a source region to a destination region.
- Two modes: fixed-length, or zero-terminated (copy until a 0x0000 word is read).
- Sits between the phase-2 control/loader logic and the data memory. Used for memory image relocation and for bench-side preload/dump.

Parameters:
- ASIZE, 16, memory address width in bits.
- DSIZE, 16, memory data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  one-cycle command strobe; accepted only when busy=0.
- src_addr  in  ASIZE  source base address; sampled on accepted start.
- dst_addr  in  ASIZE  destination base address; sampled on accepted start.
- len  in  ASIZE  word count; 0 selects zero-terminated mode. Sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  set with done if terminated mode hits the 2^ASIZE word limit; held until next accepted start.
- words_done  out  ASIZE  words written in the current/last command; held after done.
- mem_wen  out  1  memory write enable, active-low.
- mem_addr  out  ASIZE  memory address.
- mem_wdata  out  DSIZE  memory write data.
- mem_rdata  in  DSIZE  memory read data; valid the cycle after mem_addr is presented with mem_wen=1.

Behaviour:
- Reset (rst=0, async): mem_wen=1, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_done=0, state=IDLE, internal pointers cleared.
- All outputs are registered.
- States: IDLE, RD_ADDR, RD_DATA, WRITE, FIN.
- IDLE:
  - mem_wen=1.
  - On start=1: latch src/dst/len into internal pointers and remaining count, clear words_done and err, go to RD_ADDR.
- RD_ADDR: mem_addr=src pointer, mem_wen=1; go to RD_DATA.
- RD_DATA: capture mem_rdata into a data register; go to WRITE.
- WRITE:
  - mem_addr=dst pointer, mem_wdata=captured word, mem_wen=0 for exactly one cycle.
  - Increment src, dst and words_done.
  - Fixed mode: if remaining=1, go to FIN; else decrement remaining and go to RD_ADDR.
  - Terminated mode: if captured word == 0, go to FIN. The terminator is written and counted.
  - Terminated mode: else if words_done reaches 2^ASIZE-1 after this write, set err and go to FIN. Else go to RD_ADDR.
- FIN: mem_wen=1, done=1 for one cycle, busy=0 from the next cycle; go to IDLE.
- Throughput: 3 cycles per word. Latency from accepted start to done pulse = 3*N+1 cycles; the done pulse is in the cycle after the last write.
- Address arithmetic is modulo 2^ASIZE: 0xFFFF+1 wraps to 0x0000 with no error.
- Overlapping regions are copied strictly in ascending order, word by word. Forward overlap (dst>src within len) replicates data; this is defined behaviour, not an error.
- start while busy=1 is ignored with no side effects. start during the FIN cycle is also ignored.
- Reset asserted mid-command: immediate return to reset values, mem_wen=1 within the same cycle (async). The partially copied region is left as written.
- mem_addr holds its last value in IDLE. mem_wdata holds the last written word.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding constants (IDLE=0, RD_ADDR=1, RD_DATA=2, WRITE=3, FIN=4, 3-bit);
  - MEM_WEN_ACTIVE=1'b0 / MEM_WEN_IDLE=1'b1;
  - default ASIZE/DSIZE.
- Single module; no sub-module is warranted. The memory model used in benches is the existing data memory.

Test Plan:
- Fixed length: preload mem[0x0010..0x0013]=A1,B2,C3,D4; start src=0x0010 dst=0x0100 len=4.
  - mem[0x0100..0x0103]=A1,B2,C3,D4.
  - done pulses 13 cycles after start; words_done=4; err=0.
- Terminated: preload mem[0x20..0x22]=1111,2222,0000; start len=0 src=0x20 dst=0x80.
  - mem[0x80..0x82]=1111,2222,0000.
  - words_done=3; mem[0x83] untouched.
- Wrap: preload mem[0xFFFE]=0x5A5A, mem[0xFFFF]=0x6B6B, mem[0x0000]=0x7C7C; start src=0xFFFE dst=0x0200 len=3.
  - mem[0x200..0x202]=5A5A,6B6B,7C7C; err=0.
- Busy ignore: issue start with len=2, then pulse start again with different src/dst at cycle +2.
  - Only the first command executes; exactly one done pulse; words_done=2.
- Reset mid-op: start len=8, assert rst=0 during the 4th WRITE.
  - mem_wen=1 immediately; busy=0, words_done=0.
  - Exactly 3 destination words written (4th write aborted).
  - A subsequent start with len=1 completes normally.
- Terminator limit: fill entire memory with 0xFFFF, start len=0.
  - err=1 with done after 65535 writes; words_done=0xFFFF.
